cpu_wb_initiator: RTL and testbench
===================================

// Module: cpu_wb_initiator
// PURPOSE
//  CPU-side Wishbone master: turns PDP2011 core word/byte load/store requests into single Wishbone cycles.
//  It is the initiator for the internal register responders, the I/O page and RAM.
//  Detects odd-address word accesses and bus timeouts.
//  Produces one-cycle pulses for the odd-address, NXM and I/O-bus-timeout error flags feeding the CER.
// PARAMETERS
//  TIMEOUT_CYCLES  64          cycles with stb high and no ack before a bus timeout is declared
//  IOPAGE_BASE     22'o17760000  first address of the I/O page; addresses >= this are I/O, below are RAM
// PORTS
//  wb_clk_i           in   1   clock
//  wb_rst_i           in   1   reset, asynchronous, active-high
//  cpu_req            in   1   transfer request, level; held until cpu_done seen
//  cpu_we             in   1   1=write 0=read
//  cpu_byte           in   1   1=byte access 0=word access
//  cpu_addr           in   22  physical byte address
//  cpu_wdata          in   16  write data; byte writes use [7:0]
//  cpu_rdata          out  16  read data; valid when cpu_done & ~cpu_err
//  cpu_done           out  1   one-cycle completion pulse
//  cpu_err            out  1   qualifies cpu_done: transfer failed
//  cpu_address_error  out  1   one-cycle pulse: word access to odd address
//  cpu_nxm            out  1   one-cycle pulse: timeout, RAM range
//  cpu_iobus_timeout  out  1   one-cycle pulse: timeout, I/O page
//  wb_adr_o           out  22  address, bit0 forced 0
//  wb_dat_o           out  16  write data
//  wb_dat_i           in   16  read data
//  wb_we_o            out  1   write enable
//  wb_sel_o           out  2   byte lanes
//  wb_cyc_o           out  1   cycle
//  wb_stb_o           out  1   strobe
//  wb_ack_i           in   1   acknowledge
// BEHAVIOUR
//  Reset values: all outputs 0; state = IDLE; timeout counter = 0.
//  States:
//   - IDLE: when cpu_req=1, latch addr, we, byte and wdata.
//     - If ~cpu_byte & cpu_addr[0]: go to ERR; no bus cycle; cpu_address_error pulses.
//     - Otherwise go to BUS. Next cycle: cyc=stb=1; adr, we, sel and dat_o are registered.
//   - BUS: hold cyc/stb and all bus outputs stable.
//     - On ack: drop cyc/stb on the next edge, capture rdata, go to DONE.
//     - No ack while counter = TIMEOUT_CYCLES-1: drop cyc/stb and go to ERR.
//       Pulse cpu_iobus_timeout if addr >= IOPAGE_BASE, else pulse cpu_nxm.
//   - DONE: cpu_done=1, cpu_err=0 for one cycle, then IDLE.
//   - ERR: cpu_done=1, cpu_err=1 for one cycle, then IDLE.
//  Handshake: the CPU drops cpu_req in the cycle it sees cpu_done. A req still high in IDLE starts a new transfer.
//  Latency with a registered-ack responder (ack 1 cycle after stb):
//   - req at edge N; cyc/stb high from N+1; ack seen at N+2; cpu_done at N+3.
//   - Minimum spacing between transfers is 4 cycles.
//  Lanes and data:
//   - Word access: sel=2'b11, dat_o=wdata.
//   - Byte access: sel=addr[0] ? 2'b10 : 2'b01; dat_o={wdata[7:0], wdata[7:0]}.
//   - Byte read: rdata={8'h00, addr[0] ? dat_i[15:8] : dat_i[7:0]}.
//   - Word read: rdata=dat_i.
//  Timeout counter: cleared on entry to BUS; increments each BUS cycle without ack; saturating.
//  Boundaries:
//   - ack in the same cycle as terminal count: ack wins, normal DONE.
//   - ack outside BUS: ignored.
//   - cpu_rdata holds its last value through IDLE and error transfers.
//   - Async reset mid-cycle: cyc/stb drop immediately; no done/error pulse is produced.
// CONFIGURATION
//  Macro WB_TIMEOUT_EN:
//   - Defined: timeout counter is present; behaviour as above.
//   - Undefined: no counter; BUS waits indefinitely for ack; cpu_nxm and cpu_iobus_timeout are tied 0.
//     Odd-address detection is unaffected.
// STRUCTURE
//  Package cpu_bus_pkg:
//   - state enum {IDLE, BUS, DONE, ERR}
//   - IOPAGE_BASE default
//   - sel encoding constants SEL_WORD, SEL_LO, SEL_HI
//  Sub-module cpu_wb_timeout: clear/count/expired interface, width $clog2(TIMEOUT_CYCLES).
//   Instantiated only under WB_TIMEOUT_EN.
// TESTING
//  1. Word read 17777776; responder acks 1 cycle later with 16'o000340
//     -> sel=11; cpu_done at N+3; rdata=000340; err=0.
//  2. Byte write 0x55 to 17777777 -> sel=10, dat_o=16'h5555, we=1; one cycle only; done, err=0.
//  3. Word read 001001 (odd) -> no cyc ever; cpu_address_error pulse; done+err in next cycle.
//  4. Read 000100 with no ack, TIMEOUT_CYCLES=64 -> stb high exactly 64 cycles; cpu_nxm pulse; done+err.
//     Repeat at 17777700 -> cpu_iobus_timeout pulse instead.
//  5. ack arriving on the terminal-count cycle -> normal done, no timeout pulse.
//  6. Assert reset with stb high -> cyc/stb 0 same cycle, no done.
//     After release, a req is serviced normally.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU-side Wishbone initiator:
// FSM state encoding, I/O page base address and byte-lane select codes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [21:0] IOPAGE_BASE_DEF = 22'o17760000;

  localparam logic [1:0] SEL_WORD = 2'b11;
  localparam logic [1:0] SEL_LO   = 2'b01;
  localparam logic [1:0] SEL_HI   = 2'b10;

  function automatic logic [1:0] lane_sel(input logic is_byte, input logic a0);
    logic [1:0] sel;
    if (!is_byte) begin
      sel = SEL_WORD;
    end else if (a0) begin
      sel = SEL_HI;
    end else begin
      sel = SEL_LO;
    end
    return sel;
  endfunction

  // Byte reads return the addressed lane zero-extended into the low byte.
  function automatic logic [15:0] read_align(input logic is_byte, input logic a0,
                                             input logic [15:0] bus_data);
    logic [15:0] res;
    if (!is_byte) begin
      res = bus_data;
    end else if (a0) begin
      res = {8'h00, bus_data[15:8]};
    end else begin
      res = {8'h00, bus_data[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_wb_timeout.sv
// Saturating bus-cycle watchdog: cleared on entry to a bus cycle, counts
// cycles without ack, flags expiry on the terminal count.
module cpu_wb_timeout #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_r;

  // Counter register; holds at the terminal count until cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (count && (cnt_r != TERM)) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == TERM);

endmodule

// File: rtl/cpu_wb_initiator.sv
// CPU-side Wishbone initiator: one single Wishbone cycle per core load/store,
// with odd-address detection. Bus timeout (NXM / I/O-bus) is built only when WB_TIMEOUT_EN is defined.
module cpu_wb_initiator
  import cpu_bus_pkg::*;
#(
`ifdef WB_TIMEOUT_EN
  parameter int          TIMEOUT_CYCLES = 64,
`endif
  parameter logic [21:0] IOPAGE_BASE    = IOPAGE_BASE_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_byte,
  input  logic [21:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        cpu_address_error,
  output logic        cpu_nxm,
  output logic        cpu_iobus_timeout,
  output logic [21:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  output logic        wb_we_o,
  output logic [1:0]  wb_sel_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i
);

  state_t      state_r, state_nxt;
  logic [21:0] adr_r, adr_nxt;
  logic [15:0] dat_r, dat_nxt;
  logic        we_r, we_nxt;
  logic [1:0]  sel_r, sel_nxt;
  logic        cyc_r, cyc_nxt;
  logic        a0_r, a0_nxt;
  logic        byte_r, byte_nxt;
  logic [15:0] rdata_r, rdata_nxt;
  logic        done_r, done_nxt;
  logic        err_r, err_nxt;
  logic        aerr_r, aerr_nxt;
  logic        nxm_r, nxm_nxt;
  logic        iot_r, iot_nxt;
  logic        odd_word_s;
  logic        tmo_expired_s;

  assign odd_word_s = ~cpu_byte & cpu_addr[0];

`ifdef WB_TIMEOUT_EN
  logic tmo_clear_s;
  logic tmo_count_s;

  assign tmo_clear_s = (state_r == IDLE) & cpu_req & ~odd_word_s;
  assign tmo_count_s = (state_r == BUS) & ~wb_ack_i;

  cpu_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clear   (tmo_clear_s),
    .count   (tmo_count_s),
    .expired (tmo_expired_s)
  );
`else
  assign tmo_expired_s = 1'b0;
`endif

  // Next-state and next-output logic; every output is a registered version of these.
  always_comb begin
    state_nxt = state_r;
    adr_nxt   = adr_r;
    dat_nxt   = dat_r;
    we_nxt    = we_r;
    sel_nxt   = sel_r;
    a0_nxt    = a0_r;
    byte_nxt  = byte_r;
    rdata_nxt = rdata_r;
    cyc_nxt   = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    aerr_nxt  = 1'b0;
    nxm_nxt   = 1'b0;
    iot_nxt   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          a0_nxt   = cpu_addr[0];
          byte_nxt = cpu_byte;
          if (odd_word_s) begin
            state_nxt = ERR;
            aerr_nxt  = 1'b1;
          end else begin
            state_nxt = BUS;
            cyc_nxt   = 1'b1;
            adr_nxt   = {cpu_addr[21:1], 1'b0};
            we_nxt    = cpu_we;
            sel_nxt   = lane_sel(cpu_byte, cpu_addr[0]);
            dat_nxt   = cpu_byte ? {cpu_wdata[7:0], cpu_wdata[7:0]} : cpu_wdata;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUS: begin
        // An ack on the terminal-count cycle takes priority over the timeout.
        if (wb_ack_i) begin
          state_nxt = DONE;
          if (!we_r) begin
            rdata_nxt = read_align(byte_r, a0_r, wb_dat_i);
          end else begin
            rdata_nxt = rdata_r;
          end
        end else if (tmo_expired_s) begin
          state_nxt = ERR;
          if (adr_r >= IOPAGE_BASE) begin
            iot_nxt = 1'b1;
          end else begin
            nxm_nxt = 1'b1;
          end
        end else begin
          state_nxt = BUS;
          cyc_nxt   = 1'b1;
        end
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done_nxt  = 1'b1;
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops cyc/stb and all pulses at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      adr_r   <= 22'd0;
      dat_r   <= 16'd0;
      we_r    <= 1'b0;
      sel_r   <= 2'b00;
      cyc_r   <= 1'b0;
      a0_r    <= 1'b0;
      byte_r  <= 1'b0;
      rdata_r <= 16'd0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      aerr_r  <= 1'b0;
      nxm_r   <= 1'b0;
      iot_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      adr_r   <= adr_nxt;
      dat_r   <= dat_nxt;
      we_r    <= we_nxt;
      sel_r   <= sel_nxt;
      cyc_r   <= cyc_nxt;
      a0_r    <= a0_nxt;
      byte_r  <= byte_nxt;
      rdata_r <= rdata_nxt;
      done_r  <= done_nxt;
      err_r   <= err_nxt;
      aerr_r  <= aerr_nxt;
      nxm_r   <= nxm_nxt;
      iot_r   <= iot_nxt;
    end
  end

  assign cpu_rdata         = rdata_r;
  assign cpu_done          = done_r;
  assign cpu_err           = err_r;
  assign cpu_address_error = aerr_r;
  assign cpu_nxm           = nxm_r;
  assign cpu_iobus_timeout = iot_r;
  assign wb_adr_o          = adr_r;
  assign wb_dat_o          = dat_r;
  assign wb_we_o           = we_r;
  assign wb_sel_o          = sel_r;
  assign wb_cyc_o          = cyc_r;
  assign wb_stb_o          = cyc_r;

endmodule

// File: tb/tb_cpu_wb_initiator.sv
// Scoreboard bench for cpu_wb_initiator: directed cases then random transfers,
// expected results from a transfer-level model, checked by an independent monitor.
module tb_cpu_wb_initiator;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_byte;
  logic [21:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_err;
  logic        cpu_address_error;
  logic        cpu_nxm;
  logic        cpu_iobus_timeout;
  logic [21:0] wb_adr_o;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i;
  logic        wb_we_o;
  logic [1:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_ack_i;

  cpu_wb_initiator dut (
    .wb_clk_i          (wb_clk_i),
    .wb_rst_i          (wb_rst_i),
    .cpu_req           (cpu_req),
    .cpu_we            (cpu_we),
    .cpu_byte          (cpu_byte),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .cpu_done          (cpu_done),
    .cpu_err           (cpu_err),
    .cpu_address_error (cpu_address_error),
    .cpu_nxm           (cpu_nxm),
    .cpu_iobus_timeout (cpu_iobus_timeout),
    .wb_adr_o          (wb_adr_o),
    .wb_dat_o          (wb_dat_o),
    .wb_dat_i          (wb_dat_i),
    .wb_we_o           (wb_we_o),
    .wb_sel_o          (wb_sel_o),
    .wb_cyc_o          (wb_cyc_o),
    .wb_stb_o          (wb_stb_o),
    .wb_ack_i          (wb_ack_i)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  localparam int          TMO    = 64;
  localparam logic [21:0] IOBASE = 22'o17760000;
`ifdef WB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit          err;
    int          aerr;
    int          nxm;
    int          iot;
    int          stb_cycles;
    int          lat;
    bit          chk_rdata;
    logic [15:0] rdata;
    logic [21:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    bit          we;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          errors;
  bit          mon_en;
  int          resp_k;
  logic [15:0] resp_data;
  logic [15:0] model_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  // Responder: ack on the k-th cycle of a strobe; stray acks only while no strobe.
  initial begin
    int j;
    j        = 0;
    wb_ack_i = 1'b0;
    wb_dat_i = 16'h0000;
    forever begin
      @(posedge wb_clk_i);
      #1;
      if (wb_stb_o) begin
        wb_ack_i = (j == resp_k - 1);
        wb_dat_i = wb_ack_i ? resp_data : 16'($urandom);
        j++;
      end else begin
        j        = 0;
        wb_ack_i = ($urandom_range(0, 7) == 0);
        wb_dat_i = 16'($urandom);
      end
    end
  end

  // Transfer-level model: outcome, latency and bus image follow from address, size and ack delay k.
  task automatic do_txn(input logic [21:0] addr, input bit we, input bit byt,
                        input logic [15:0] wd, input logic [15:0] rd, input int k);
    exp_t e;
    bit   odd;
    bit   tmo;
    bit   seen;
    odd = !byt && addr[0];
    tmo = !odd && TMO_EN && (k > TMO);
    e = '{default: 0};
    if (odd) begin
      e.err = 1'b1; e.aerr = 1; e.lat = 1;
      e.chk_rdata = 1'b1; e.rdata = model_rdata;
    end else if (tmo) begin
      e.err = 1'b1;
      if (addr >= IOBASE) e.iot = 1; else e.nxm = 1;
      e.stb_cycles = TMO; e.lat = TMO + 1;
      e.chk_rdata = 1'b1; e.rdata = model_rdata;
    end else begin
      e.stb_cycles = k; e.lat = k + 1;
      if (!we) begin
        if (!byt) model_rdata = rd;
        else if (addr[0]) model_rdata = {8'h00, rd[15:8]};
        else model_rdata = {8'h00, rd[7:0]};
        e.chk_rdata = 1'b1; e.rdata = model_rdata;
      end
    end
    if (!odd) begin
      e.adr = {addr[21:1], 1'b0};
      e.we  = we;
      e.sel = !byt ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
      e.dat = byt ? {wd[7:0], wd[7:0]} : wd;
    end
    exp_q.push_back(e);
    resp_k    = k;
    resp_data = rd;
    @(posedge wb_clk_i);
    #1;
    cpu_req = 1'b1; cpu_we = we; cpu_byte = byt; cpu_addr = addr; cpu_wdata = wd;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge wb_clk_i);
      if (cpu_done) begin
        seen    = 1'b1;
        cpu_req = 1'b0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_wait: no cpu_done within 400 cycles for addr %o", addr);
      finish_sim();
    end
    repeat ($urandom_range(0, 2)) @(posedge wb_clk_i);
  endtask

  // Monitor: follows each transfer from request to done and compares with the scoreboard.
  initial begin : monitor
    bit          active;
    int          idx, stb_n, aerr_n, nxm_n, iot_n, flag_idx, bad_cs, unstable;
    logic [21:0] adr_s;
    logic [15:0] dat_s;
    logic [1:0]  sel_s;
    logic        we_s;
    exp_t        e;
    active = 1'b0;
    idx = 0; stb_n = 0; aerr_n = 0; nxm_n = 0; iot_n = 0; flag_idx = 0; bad_cs = 0; unstable = 0;
    adr_s = '0; dat_s = '0; sel_s = '0; we_s = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (!mon_en) begin
        active = 1'b0;
      end else begin
        if (!active && cpu_req) begin
          active = 1'b1;
          idx = 0; stb_n = 0; aerr_n = 0; nxm_n = 0; iot_n = 0; flag_idx = 0; bad_cs = 0; unstable = 0;
        end else if (active) begin
          idx++;
        end
        if (active) begin
          if (wb_cyc_o !== wb_stb_o) bad_cs++;
          if (wb_stb_o) begin
            if (stb_n > 0 && {wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o} !== {adr_s, dat_s, sel_s, we_s})
              unstable++;
            adr_s = wb_adr_o; dat_s = wb_dat_o; sel_s = wb_sel_o; we_s = wb_we_o;
            stb_n++;
          end
          if (cpu_address_error) begin aerr_n++; flag_idx = idx; end
          if (cpu_nxm)           begin nxm_n++;  flag_idx = idx; end
          if (cpu_iobus_timeout) begin iot_n++;  flag_idx = idx; end
          if (cpu_done) begin
            active = 1'b0;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_done: cpu_done with no transfer outstanding");
            end else begin
              e = exp_q.pop_front();
              check("latency", 32'(idx - 1), 32'(e.lat));
              check("err", 32'(cpu_err), 32'(e.err));
              check("addr_err_pulses", 32'(aerr_n), 32'(e.aerr));
              check("nxm_pulses", 32'(nxm_n), 32'(e.nxm));
              check("iot_pulses", 32'(iot_n), 32'(e.iot));
              check("stb_cycles", 32'(stb_n), 32'(e.stb_cycles));
              check("cyc_eq_stb", 32'(bad_cs), 32'd0);
              check("bus_stable", 32'(unstable), 32'd0);
              if (e.aerr + e.nxm + e.iot > 0) check("flag_timing", 32'(flag_idx), 32'(idx - 1));
              if (e.chk_rdata) check("rdata", 32'(cpu_rdata), 32'(e.rdata));
              if (e.stb_cycles > 0) begin
                check("adr", 32'(adr_s), 32'(e.adr));
                check("sel", 32'(sel_s), 32'(e.sel));
                check("we", 32'(we_s), 32'(e.we));
                check("dat_o", 32'(dat_s), 32'(e.dat));
              end
            end
          end
        end else if (cpu_done | cpu_err | wb_stb_o | wb_cyc_o | cpu_address_error | cpu_nxm | cpu_iobus_timeout) begin
          checks++;
          errors++;
          $display("FAIL idle_activity: done=%b err=%b stb=%b cyc=%b aerr=%b nxm=%b iot=%b, expected all 0",
                   cpu_done, cpu_err, wb_stb_o, wb_cyc_o, cpu_address_error, cpu_nxm, cpu_iobus_timeout);
        end
      end
    end
  end

  initial begin
    bit done_seen;
    bit stb_seen;
    checks = 0; errors = 0;
    wb_rst_i = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 22'd0; cpu_wdata = 16'd0;
    mon_en = 1'b0; model_rdata = 16'h0000; resp_k = 2; resp_data = 16'h0000;
    repeat (3) @(negedge wb_clk_i);
    check("rst_cpu_flags", 32'({cpu_done, cpu_err, cpu_address_error, cpu_nxm, cpu_iobus_timeout}), 32'd0);
    check("rst_bus_ctrl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'd0);
    check("rst_adr", 32'(wb_adr_o), 32'd0);
    check("rst_dat_o", 32'(wb_dat_o), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    mon_en   = 1'b1;

    // Directed cases
    do_txn(22'o17777776, 1'b0, 1'b0, 16'h0000, 16'o000340, 2);
    do_txn(22'o17777777, 1'b1, 1'b1, 16'h0055, 16'hBEEF, 2);
    do_txn(22'o00001001, 1'b0, 1'b0, 16'h1111, 16'h2222, 2);
`ifdef WB_TIMEOUT_EN
    do_txn(22'o00000100, 1'b0, 1'b0, 16'h0000, 16'h3333, 1000);
    do_txn(22'o17777700, 1'b0, 1'b0, 16'h0000, 16'h4444, 1000);
`else
    do_txn(22'o00000100, 1'b0, 1'b0, 16'h0000, 16'h3333, 150);
`endif
    do_txn(22'o00000200, 1'b0, 1'b0, 16'h0000, 16'hA5C3, 64);
    do_txn(22'o17760000, 1'b0, 1'b1, 16'h0000, 16'h7E81, 63);
    do_txn(22'o17757776, 1'b0, 1'b1, 16'h0000, 16'h9ABC, 1);

    // Async reset while a bus cycle is open
    @(posedge wb_clk_i);
    #1;
    mon_en    = 1'b0;
    resp_k    = 40;
    resp_data = 16'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 22'o00000400;
    stb_seen = 1'b0;
    for (int n = 0; n < 10 && !stb_seen; n++) begin
      @(negedge wb_clk_i);
      stb_seen = wb_stb_o;
    end
    check("rst_test_stb_open", 32'(stb_seen), 32'd1);
    repeat (3) @(negedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    check("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    cpu_req = 1'b0;
    done_seen = 1'b0;
    repeat (3) begin
      @(negedge wb_clk_i);
      done_seen = done_seen | cpu_done | cpu_err;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);
    wb_rst_i    = 1'b0;
    model_rdata = 16'h0000;
    @(posedge wb_clk_i);
    #1;
    mon_en = 1'b1;
    do_txn(22'o00000402, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 2);

    // Random transfers
    for (int t = 0; t < 40; t++) begin
      logic [21:0] a;
      int          k;
      int          r;
      r = $urandom_range(0, 3);
      case (r)
        0: a = 22'($urandom_range(0, 32'(IOBASE) - 1));
        1: a = IOBASE + 22'($urandom_range(0, 8191));
        2: a = IOBASE - 22'($urandom_range(0, 3));
        default: a = 22'($urandom);
      endcase
      r = $urandom_range(0, 9);
      if (r == 0) k = $urandom_range(63, 64);
      else if (r == 1) k = 65 + $urandom_range(0, 40);
      else k = $urandom_range(1, 4);
      do_txn(a, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), k);
    end

    repeat (4) @(negedge wb_clk_i);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    finish_sim();
  end

endmodule
